// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster timing constants, count widths and a coordinate type
// for the video timing generator and the renderers that consume its position.
package video_timing_pkg;

  localparam int unsigned DEF_ACTIVE_H = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_ACTIVE_V = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;
  localparam int unsigned DEF_FPS      = 60;

  localparam int unsigned DEF_H_TOTAL = DEF_ACTIVE_H + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_ACTIVE_V + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_W  = $clog2(DEF_H_TOTAL);
  localparam int DEF_V_W  = $clog2(DEF_V_TOTAL);
  localparam int DEF_FC_W = $clog2(DEF_FPS);

  typedef struct packed {
    logic [DEF_H_W-1:0] h;
    logic [DEF_V_W-1:0] v;
  } coord_t;

  // True when pos lies in the half-open window [lo, lo+len).
  function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                     input int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up-counter with an enable; wrap_out flags the increment
// that takes the count from MAX back to zero.
module wrap_counter #(
  parameter int unsigned      MAX       = 1,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_pixel_in,
  input  logic             rst_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap_out
);

  assign wrap_out = inc_in && (count_out == WIDTH'(MAX));

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      count_out <= RESET_VAL;
    end else if (inc_in) begin
      count_out <= wrap_out ? '0 : count_out + WIDTH'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: walks every pixel of the frame and emits aligned
// coordinates, syncs, active-draw, new-frame strobe and a frame counter.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H = DEF_ACTIVE_H,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned ACTIVE_V = DEF_ACTIVE_V,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned FPS      = DEF_FPS,
  localparam int unsigned H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP,
  localparam int H_W  = $clog2(H_TOTAL),
  localparam int V_W  = $clog2(V_TOTAL),
  localparam int FC_W = $clog2(FPS)
) (
  input  logic            clk_pixel_in,
  input  logic            rst_in,
  output logic [H_W-1:0]  h_count_out,
  output logic [V_W-1:0]  v_count_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            ad_out,
  output logic            nf_out,
  output logic [FC_W-1:0] fc_out
);

  logic           h_wrap, v_wrap, fc_wrap;
  logic [H_W-1:0] h_next;
  logic [V_W-1:0] v_next;
  logic           hs_next, vs_next, ad_next, nf_next;

  // Reset parks the raster on the last blanking pixel so the first edge lands on (0,0).
  wrap_counter #(.MAX(H_TOTAL - 1), .WIDTH(H_W), .RESET_VAL(H_W'(H_TOTAL - 1))) u_h_cnt (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .inc_in       (1'b1),
    .count_out    (h_count_out),
    .wrap_out     (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1), .WIDTH(V_W), .RESET_VAL(V_W'(V_TOTAL - 1))) u_v_cnt (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .inc_in       (h_wrap),
    .count_out    (v_count_out),
    .wrap_out     (v_wrap)
  );

  wrap_counter #(.MAX(FPS - 1), .WIDTH(FC_W), .RESET_VAL('0)) u_frame_cnt (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .inc_in       (nf_next),
    .count_out    (fc_out),
    .wrap_out     (fc_wrap)
  );

  // Flags are decoded from the position the counters move to on this edge,
  // so once registered they line up with h/v without skew.
  always_comb begin
    h_next  = h_wrap ? '0 : h_count_out + H_W'(1);
    v_next  = v_count_out;
    if (v_wrap) begin
      v_next = '0;
    end else if (h_wrap) begin
      v_next = v_count_out + V_W'(1);
    end
    hs_next = in_window(32'(h_next), ACTIVE_H + H_FP, H_SYNC);
    vs_next = in_window(32'(v_next), ACTIVE_V + V_FP, V_SYNC);
    ad_next = (32'(h_next) < ACTIVE_H) && (32'(v_next) < ACTIVE_V);
    nf_next = (32'(h_next) == ACTIVE_H) && (32'(v_next) == ACTIVE_V);
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      ad_out <= 1'b0;
      nf_out <= 1'b0;
    end else begin
      hs_out <= hs_next;
      vs_out <= vs_next;
      ad_out <= ad_next;
      nf_out <= nf_next;
    end
  end

  // The frame counter may only roll over from its top value.
  assert property (@(posedge clk_pixel_in) disable iff (rst_in)
                   fc_wrap |-> (fc_out == FC_W'(FPS - 1)));

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a 720p instance for line timing and a tiny-raster
// instance for frame, frame-counter and mid-frame reset behaviour.
module tb_video_timing_gen;

  localparam int A_HT = 1650, A_VT = 750;
  localparam int A_HW = $clog2(A_HT), A_VW = $clog2(A_VT), A_FW = $clog2(60);

  localparam int B_AH = 8, B_HFP = 1, B_HSW = 2, B_HBP = 1;
  localparam int B_AV = 4, B_VFP = 1, B_VSW = 1, B_VBP = 1;
  localparam int B_FPS = 4;
  localparam int B_HT = B_AH + B_HFP + B_HSW + B_HBP;
  localparam int B_VT = B_AV + B_VFP + B_VSW + B_VBP;
  localparam int B_FRAME = B_HT * B_VT;
  localparam int B_HW = $clog2(B_HT), B_VW = $clog2(B_VT), B_FW = $clog2(B_FPS);

  typedef struct {
    int h; int v; int hs; int vs; int ad; int nf; int fc;
  } exp_t;

  typedef struct {
    int p; int h; int v; int hs; int ad;
  } spot_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  logic [A_HW-1:0] a_h;
  logic [A_VW-1:0] a_v;
  logic            a_hs, a_vs, a_ad, a_nf;
  logic [A_FW-1:0] a_fc;

  logic [B_HW-1:0] b_h;
  logic [B_VW-1:0] b_v;
  logic            b_hs, b_vs, b_ad, b_nf;
  logic [B_FW-1:0] b_fc;

  video_timing_gen dut_a (
    .clk_pixel_in (clk),
    .rst_in       (rst_a),
    .h_count_out  (a_h),
    .v_count_out  (a_v),
    .hs_out       (a_hs),
    .vs_out       (a_vs),
    .ad_out       (a_ad),
    .nf_out       (a_nf),
    .fc_out       (a_fc)
  );

  video_timing_gen #(
    .ACTIVE_H (B_AH), .H_FP (B_HFP), .H_SYNC (B_HSW), .H_BP (B_HBP),
    .ACTIVE_V (B_AV), .V_FP (B_VFP), .V_SYNC (B_VSW), .V_BP (B_VBP),
    .FPS      (B_FPS)
  ) dut_b (
    .clk_pixel_in (clk),
    .rst_in       (rst_b),
    .h_count_out  (b_h),
    .v_count_out  (b_v),
    .hs_out       (b_hs),
    .vs_out       (b_vs),
    .ad_out       (b_ad),
    .nf_out       (b_nf),
    .fc_out       (b_fc)
  );

  // Scoreboard state
  int vectors = 0;
  int miscompares = 0;
  logic [B_FW-1:0] exp_q[$];
  int pa, pb, last_nf;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: position p cycles after release, derived from raster arithmetic.
  function automatic exp_t model(input int p, input int ah, input int hfp, input int hsw,
                                 input int hbp, input int av, input int vfp, input int vsw,
                                 input int vbp, input int fps);
    exp_t e;
    int ht, vt, flen, f, q;
    ht   = ah + hfp + hsw + hbp;
    vt   = av + vfp + vsw + vbp;
    flen = ht * vt;
    f    = p / flen;
    q    = p % flen;
    e.h  = q % ht;
    e.v  = q / ht;
    e.hs = (e.h >= ah + hfp && e.h < ah + hfp + hsw) ? 1 : 0;
    e.vs = (e.v >= av + vfp && e.v < av + vfp + vsw) ? 1 : 0;
    e.ad = (e.h < ah && e.v < av) ? 1 : 0;
    e.nf = (e.h == ah && e.v == av) ? 1 : 0;
    e.fc = (f + ((q >= av * ht + ah) ? 1 : 0)) % fps;
    return e;
  endfunction

  function automatic exp_t model_a(input int p);
    return model(p, 1280, 110, 40, 220, 720, 5, 5, 20, 60);
  endfunction

  function automatic exp_t model_b(input int p);
    return model(p, B_AH, B_HFP, B_HSW, B_HBP, B_AV, B_VFP, B_VSW, B_VBP, B_FPS);
  endfunction

  function automatic exp_t reset_exp(input int ht, input int vt);
    exp_t e;
    e = '{h: ht - 1, v: vt - 1, hs: 0, vs: 0, ad: 0, nf: 0, fc: 0};
    return e;
  endfunction

  task automatic check_a(input string tag, input exp_t e);
    cmp({tag, " h"}, int'(a_h), e.h);
    cmp({tag, " v"}, int'(a_v), e.v);
    cmp({tag, " hs"}, int'(a_hs), e.hs);
    cmp({tag, " vs"}, int'(a_vs), e.vs);
    cmp({tag, " ad"}, int'(a_ad), e.ad);
    cmp({tag, " nf"}, int'(a_nf), e.nf);
    cmp({tag, " fc"}, int'(a_fc), e.fc);
  endtask

  task automatic check_b(input string tag, input exp_t e);
    cmp({tag, " h"}, int'(b_h), e.h);
    cmp({tag, " v"}, int'(b_v), e.v);
    cmp({tag, " hs"}, int'(b_hs), e.hs);
    cmp({tag, " vs"}, int'(b_vs), e.vs);
    cmp({tag, " ad"}, int'(b_ad), e.ad);
    cmp({tag, " nf"}, int'(b_nf), e.nf);
    cmp({tag, " fc"}, int'(b_fc), e.fc);
  endtask

  // Driver tasks
  task automatic step_a();
    @(posedge clk);
    #1;
    check_a("a_run", model_a(pa));
    pa++;
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
    check_b("b_run", model_b(pb));
    if (b_nf === 1'b1) begin
      if (exp_q.size() > 0) cmp("b_fc_at_nf", int'(b_fc), int'(exp_q.pop_front()));
      if (last_nf >= 0) cmp("b_nf_spacing", pb - last_nf, B_FRAME);
      last_nf = pb;
    end
    pb++;
  endtask

  task automatic async_reset_b(input int hold);
    rst_b = 1'b1;
    #1;
    check_b("b_async", reset_exp(B_HT, B_VT));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check_b("b_hold", reset_exp(B_HT, B_VT));
    end
    rst_b = 1'b0;
    pb = 0;
    last_nf = -1;
  endtask

  initial begin
    spot_t spots[11];
    int hs_cnt, ad_cnt;
    logic [B_FW-1:0] fc_seq[10];

    spots[0]  = '{p: 0,    h: 0,    v: 0, hs: 0, ad: 1};
    spots[1]  = '{p: 1279, h: 1279, v: 0, hs: 0, ad: 1};
    spots[2]  = '{p: 1280, h: 1280, v: 0, hs: 0, ad: 0};
    spots[3]  = '{p: 1389, h: 1389, v: 0, hs: 0, ad: 0};
    spots[4]  = '{p: 1390, h: 1390, v: 0, hs: 1, ad: 0};
    spots[5]  = '{p: 1429, h: 1429, v: 0, hs: 1, ad: 0};
    spots[6]  = '{p: 1430, h: 1430, v: 0, hs: 0, ad: 0};
    spots[7]  = '{p: 1649, h: 1649, v: 0, hs: 0, ad: 0};
    spots[8]  = '{p: 1650, h: 0,    v: 1, hs: 0, ad: 1};
    spots[9]  = '{p: 3299, h: 1649, v: 1, hs: 0, ad: 0};
    spots[10] = '{p: 3300, h: 0,    v: 2, hs: 0, ad: 1};
    fc_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    check_a("a_reset", reset_exp(A_HT, A_VT));
    check_b("b_reset", reset_exp(B_HT, B_VT));

    // 720p line timing against spot table and model
    rst_a = 1'b0;
    pa = 0;
    hs_cnt = 0;
    ad_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      while (pa <= spots[i].p) begin
        if (pa == spots[i].p) begin
          step_a();
          cmp("spot h", int'(a_h), spots[i].h);
          cmp("spot v", int'(a_v), spots[i].v);
          cmp("spot hs", int'(a_hs), spots[i].hs);
          cmp("spot ad", int'(a_ad), spots[i].ad);
        end else begin
          step_a();
        end
        if (pa <= A_HT) begin
          hs_cnt += int'(a_hs);
          ad_cnt += int'(a_ad);
        end
      end
    end
    cmp("a_hs_width", hs_cnt, 40);
    cmp("a_ad_width", ad_cnt, 1280);

    // 720p asynchronous reset between edges, then restart at (0,0)
    rst_a = 1'b1;
    #1;
    check_a("a_async", reset_exp(A_HT, A_VT));
    repeat (3) begin
      @(posedge clk);
      #1;
      check_a("a_hold", reset_exp(A_HT, A_VT));
    end
    rst_a = 1'b0;
    pa = 0;
    repeat (1300) step_a();
    rst_a = 1'b1;

    // Small raster: ten uninterrupted frames, frame counter wraps modulo 4
    foreach (fc_seq[i]) exp_q.push_back(fc_seq[i]);
    rst_b = 1'b0;
    pb = 0;
    last_nf = -1;
    repeat (10 * B_FRAME) step_b();
    cmp("b_nf_count_left", exp_q.size(), 0);

    // Random mid-frame resets, each followed by a restart checked by the model
    repeat (8) begin
      int run_len;
      run_len = $urandom_range(1, 3 * B_FRAME);
      repeat (run_len) step_b();
      async_reset_b($urandom_range(1, 3));
    end

    // Reset inside the active area, then the first pulse lands at (ACTIVE_H, ACTIVE_V)
    repeat (2 * B_HT + 3) step_b();
    async_reset_b(3);
    while (pb <= B_AV * B_HT + B_AH) step_b();
    cmp("b_first_nf h", int'(b_h), 8);
    cmp("b_first_nf v", int'(b_v), 4);
    cmp("b_first_nf nf", int'(b_nf), 1);
    cmp("b_first_nf fc", int'(b_fc), 1);
    repeat (B_FRAME + 5) step_b();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
